// File: rtl/pipeline_chain_pkg.sv
// Shared definitions for the pipeline_chain address pipeline: default widths and the slot operation type.
// ADDRESS_WIDTH and ID_WIDTH may be predefined to override the defaults; PIPE_PERF_CNT_EN enables perf counters.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

package pipeline_chain_pkg;

  localparam int DefaultDepth = 4;
  localparam int DefaultAddrW = `ADDRESS_WIDTH;
  localparam int DefaultIdW   = `ID_WIDTH;
  localparam int DefaultCntW  = 16;

  typedef enum logic [1:0] {
    SlotHold    = 2'd0,
    SlotAdvance = 2'd1,
    SlotBubble  = 2'd2
  } slot_op_e;

  // A stage that is not ready holds; otherwise it takes whatever its source offers, possibly a bubble.
  function automatic slot_op_e slot_op(input logic ready, input logic src_valid);
    if (!ready) return SlotHold;
    return src_valid ? SlotAdvance : SlotBubble;
  endfunction

endpackage

// File: rtl/pipeline_chain_if.sv
// Handshake bundle between address generator, pipeline_chain and the consumer.
// master = the side that feeds addresses and accepts results; slave = the pipeline itself.
interface pipeline_chain_if
  import pipeline_chain_pkg::*;
#(
  parameter int DEPTH  = DefaultDepth,
  parameter int ADDR_W = DefaultAddrW,
  parameter int ID_W   = DefaultIdW
);

  logic [DEPTH*ADDR_W-1:0] stage_offsets;
  logic [ADDR_W-1:0]       in_address;
  logic [ID_W-1:0]         in_id;
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDR_W-1:0]       out_address;
  logic [ID_W-1:0]         out_id;
  logic                    out_valid;
  logic                    out_ready;
  logic                    in_flush;
  logic [ID_W-1:0]         in_flush_id;
  logic                    out_flush;
  logic [ID_W-1:0]         out_flush_id;

  modport master (
    output stage_offsets, in_address, in_id, in_valid, out_ready, in_flush, in_flush_id,
    input  in_ready, out_address, out_id, out_valid, out_flush, out_flush_id
  );

  modport slave (
    input  stage_offsets, in_address, in_id, in_valid, out_ready, in_flush, in_flush_id,
    output in_ready, out_address, out_id, out_valid, out_flush, out_flush_id
  );

endinterface

// File: rtl/pipeline_chain_slot.sv
// pipeline_slot: one register stage of pipeline_chain -- offset add, hold/advance/bubble mux, flush-by-ID kill.
// The kill_o port exists only when PIPE_PERF_CNT_EN is defined.
module pipeline_slot
  import pipeline_chain_pkg::*;
#(
  parameter int ADDR_W = DefaultAddrW,
  parameter int ID_W   = DefaultIdW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] offset_i,
  input  logic              src_valid_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ID_W-1:0]   src_id_i,
  input  logic              ready_i,
  input  logic              flush_i,
  input  logic [ID_W-1:0]   flush_id_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ID_W-1:0]   id_o,
  output logic              next_valid_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic              kill_o
`endif
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              pre_valid;
  logic [ADDR_W-1:0] pre_addr;
  logic [ID_W-1:0]   pre_id;
  logic              kill;
  slot_op_e          op;

  // The flush compare looks at what the stage would hold next, so an entry landing here this cycle is caught too.
  always_comb begin
    op        = slot_op(ready_i, src_valid_i);
    pre_valid = valid_q;
    pre_addr  = addr_q;
    pre_id    = id_q;
    unique case (op)
      SlotAdvance: begin
        pre_valid = 1'b1;
        pre_addr  = src_addr_i + offset_i;
        pre_id    = src_id_i;
      end
      SlotBubble: pre_valid = 1'b0;
      default: ;
    endcase
    kill    = flush_i && pre_valid && (pre_id == flush_id_i);
    valid_d = pre_valid && !kill;
    addr_d  = kill ? '0 : pre_addr;
    id_d    = kill ? '0 : pre_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
    end
  end

  assign valid_o      = valid_q;
  assign addr_o       = addr_q;
  assign id_o         = id_q;
  assign next_valid_o = valid_d;
`ifdef PIPE_PERF_CNT_EN
  assign kill_o       = kill;
`endif

endmodule

// File: rtl/pipeline_chain.sv
// pipeline_chain: DEPTH-stage address pipeline with per-stage backpressure, bubble collapsing and flush-by-ID.
// Define PIPE_PERF_CNT_EN to build the saturating stall_cycles / flush_kills counters; otherwise they read 0.
module pipeline_chain
  import pipeline_chain_pkg::*;
#(
  parameter int DEPTH  = DefaultDepth,
  parameter int ADDR_W = DefaultAddrW,
  parameter int ID_W   = DefaultIdW,
  parameter int CNT_W  = DefaultCntW
) (
  input  logic                       clk,
  input  logic                       reset,
  pipeline_chain_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cycles,
  output logic [CNT_W-1:0]           flush_kills
);

  localparam int OccW = $clog2(DEPTH+1);

  logic [DEPTH:0]    ready;
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  next_valid;
  logic [ADDR_W-1:0] addr [DEPTH];
  logic [ID_W-1:0]   id   [DEPTH];
  logic [OccW-1:0]   occupancy_q, occupancy_d;
  logic              flush_q;
  logic [ID_W-1:0]   flush_id_q;
`ifdef PIPE_PERF_CNT_EN
  logic [DEPTH-1:0]  kill;
`endif

  // A stage can take a new entry if it is empty or its own content moves on this cycle.
  always_comb begin
    ready        = '0;
    ready[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready[i] = !valid[i] || ready[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic              src_valid;
    logic [ADDR_W-1:0] src_addr;
    logic [ID_W-1:0]   src_id;

    if (i == 0) begin : g_head
      assign src_valid = bus.in_valid;
      assign src_addr  = bus.in_address;
      assign src_id    = bus.in_id;
    end else begin : g_body
      assign src_valid = valid[i-1];
      assign src_addr  = addr[i-1];
      assign src_id    = id[i-1];
    end

    pipeline_slot #(
      .ADDR_W (ADDR_W),
      .ID_W   (ID_W)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .offset_i     (bus.stage_offsets[i*ADDR_W +: ADDR_W]),
      .src_valid_i  (src_valid),
      .src_addr_i   (src_addr),
      .src_id_i     (src_id),
      .ready_i      (ready[i]),
      .flush_i      (bus.in_flush),
      .flush_id_i   (bus.in_flush_id),
      .valid_o      (valid[i]),
      .addr_o       (addr[i]),
      .id_o         (id[i]),
`ifdef PIPE_PERF_CNT_EN
      .kill_o       (kill[i]),
`endif
      .next_valid_o (next_valid[i])
    );
  end

  assign bus.in_ready    = ready[0];
  assign bus.out_valid   = valid[DEPTH-1];
  assign bus.out_address = addr[DEPTH-1];
  assign bus.out_id      = id[DEPTH-1];

  always_comb begin
    occupancy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy_d = occupancy_d + OccW'(next_valid[i]);
    end
  end

  // Flush echo runs every cycle regardless of backpressure so downstream sees each flush exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy_q <= '0;
      flush_q     <= 1'b0;
      flush_id_q  <= '0;
    end else begin
      occupancy_q <= occupancy_d;
      flush_q     <= bus.in_flush;
      flush_id_q  <= bus.in_flush_id;
    end
  end

  assign occupancy        = occupancy_q;
  assign bus.out_flush    = flush_q;
  assign bus.out_flush_id = flush_id_q;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [OccW-1:0]  kill_count;
  logic [CNT_W:0]   kills_sum;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] kills_q, kills_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    kill_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_count = kill_count + OccW'(kill[i]);
    end
    stall_d = stall_q;
    if (valid[DEPTH-1] && !bus.out_ready && (stall_q != CntMax)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    kills_sum = {1'b0, kills_q} + (CNT_W+1)'(kill_count);
    kills_d   = (kills_sum > {1'b0, CntMax}) ? CntMax : kills_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      kills_q <= '0;
    end else begin
      stall_q <= stall_d;
      kills_q <= kills_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_kills  = kills_q;
`else
  assign stall_cycles = '0;
  assign flush_kills  = '0;
`endif

endmodule

// File: tb/tb_pipeline_chain.sv
// Self-checking bench for pipeline_chain: directed scenarios plus a randomized run against an in-order queue model.
// Counter expectations follow PIPE_PERF_CNT_EN (zero when the feature is not built).
module tb_pipeline_chain;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int ID_W   = 4;
  localparam int CNT_W  = 16;
  localparam int OCC_W  = $clog2(DEPTH+1);

`ifdef PIPE_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
  } entry_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_kills;

  int vectors     = 0;
  int miscompares = 0;

  pipeline_chain_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  pipeline_chain #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .ID_W   (ID_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles),
    .flush_kills  (flush_kills)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.in_valid    = 1'b0;
    bus.in_address  = '0;
    bus.in_id       = '0;
    bus.out_ready   = 1'b0;
    bus.in_flush    = 1'b0;
    bus.in_flush_id = '0;
  endtask

  task automatic set_offsets(input logic [ADDR_W-1:0] o0, o1, o2, o3);
    bus.stage_offsets = {o3, o2, o1, o0};
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_offsets(8'h11, 8'h22, 8'h33, 8'h44);
    do_reset();
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    vectors++;
    if (bus.out_address !== '0 || bus.out_id !== '0) begin miscompares++; $display("[TB] FAIL reset_out_data: got %h/%h expected 00/0", bus.out_address, bus.out_id); end
    vectors++;
    if (occupancy !== '0) begin miscompares++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    vectors++;
    if (bus.out_flush !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_flush: got %0b expected 0", bus.out_flush); end
    vectors++;
    if (stall_cycles !== '0 || flush_kills !== '0) begin miscompares++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_kills); end
  endtask

  task automatic test_latency();
    do_reset();
    set_offsets(8'd1, 8'd2, 8'd3, 8'd4);
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_address = 8'h10;
    bus.in_id      = 4'd5;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      #1;
      vectors++;
      if (bus.out_valid !== (k == DEPTH)) begin
        miscompares++;
        $display("[TB] FAIL latency_valid_c%0d: got %0b expected %0b", k, bus.out_valid, (k == DEPTH));
      end
      if (k < DEPTH) tick();
    end
    vectors++;
    if (bus.out_address !== 8'h1A || bus.out_id !== 4'd5) begin
      miscompares++;
      $display("[TB] FAIL latency_data: got %h/%0d expected 1a/5", bus.out_address, bus.out_id);
    end
    tick();
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || occupancy !== '0) begin
      miscompares++;
      $display("[TB] FAIL latency_drain: got valid %0b occ %0d expected 0/0", bus.out_valid, occupancy);
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] expAddr;
    bit seen;
    expAddr = ADDR_W'((255 + 4 * 128) % 256);
    seen = 1'b0;
    do_reset();
    set_offsets(8'h80, 8'h80, 8'h80, 8'h80);
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_address = 8'hFF;
    bus.in_id      = 4'd9;
    tick();
    bus.in_valid = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      #1;
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        vectors++;
        if (bus.out_address !== expAddr || bus.out_id !== 4'd9) begin
          miscompares++;
          $display("[TB] FAIL wrap_data: got %h/%0d expected %h/9", bus.out_address, bus.out_id, expAddr);
        end
      end
      tick();
    end
    vectors++;
    if (!seen) begin miscompares++; $display("[TB] FAIL wrap_timeout: got no output expected one entry"); end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] base [6];
    int acc, got;
    acc = 0;
    got = 0;
    for (int k = 0; k < 6; k++) base[k] = ADDR_W'($urandom_range(0, 255));
    do_reset();
    set_offsets(8'd1, 8'd2, 8'd3, 8'd4);
    for (int w = 0; w < 8; w++) begin
      bus.in_valid   = (acc < 6);
      bus.in_address = base[acc < 6 ? acc : 5];
      bus.in_id      = ID_W'(acc);
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
      tick();
    end
    #1;
    vectors++;
    if (acc != 4) begin miscompares++; $display("[TB] FAIL bp_accepts: got %0d expected 4", acc); end
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready: got %0b expected 0", bus.in_ready); end
    vectors++;
    if (occupancy !== OCC_W'(4)) begin miscompares++; $display("[TB] FAIL bp_occupancy: got %0d expected 4", occupancy); end
    vectors++;
    if (stall_cycles !== CNT_W'(PerfEn ? 4 : 0)) begin
      miscompares++;
      $display("[TB] FAIL bp_stall_cycles: got %0d expected %0d", stall_cycles, PerfEn ? 4 : 0);
    end
    bus.out_ready = 1'b1;
    for (int w = 0; w < 40 && got < 6; w++) begin
      bus.in_valid   = (acc < 6);
      bus.in_address = base[acc < 6 ? acc : 5];
      bus.in_id      = ID_W'(acc);
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
      if (bus.out_valid) begin
        vectors++;
        if (bus.out_address !== ADDR_W'(base[got] + 8'd10) || bus.out_id !== ID_W'(got)) begin
          miscompares++;
          $display("[TB] FAIL bp_order_%0d: got %h/%0d expected %h/%0d", got, bus.out_address, bus.out_id, ADDR_W'(base[got] + 8'd10), got);
        end
        got++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    vectors++;
    if (got != 6) begin miscompares++; $display("[TB] FAIL bp_delivered: got %0d expected 6", got); end
    vectors++;
    if (bus.out_valid !== 1'b0 || occupancy !== '0) begin
      miscompares++;
      $display("[TB] FAIL bp_no_duplicate: got valid %0b occ %0d expected 0/0", bus.out_valid, occupancy);
    end
  endtask

  task automatic test_flush_multi();
    logic [ID_W-1:0]   ids [4];
    logic [ADDR_W-1:0] adr [4];
    int got;
    ids = '{4'd3, 4'd1, 4'd2, 4'd1};
    got = 0;
    do_reset();
    set_offsets(8'd0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 4; k++) begin
      adr[k]         = ADDR_W'($urandom_range(0, 255));
      bus.in_valid   = 1'b1;
      bus.in_address = adr[k];
      bus.in_id      = ids[k];
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_fill_ready_%0d: got %0b expected 1", k, bus.in_ready); end
      tick();
    end
    bus.in_valid    = 1'b0;
    bus.in_flush    = 1'b1;
    bus.in_flush_id = 4'd1;
    tick();
    bus.in_flush    = 1'b0;
    bus.in_flush_id = 4'd0;
    #1;
    vectors++;
    if (occupancy !== OCC_W'(2)) begin miscompares++; $display("[TB] FAIL flush_occupancy: got %0d expected 2", occupancy); end
    vectors++;
    if (bus.out_flush !== 1'b1 || bus.out_flush_id !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL flush_echo: got %0b/%0d expected 1/1", bus.out_flush, bus.out_flush_id);
    end
    vectors++;
    if (flush_kills !== CNT_W'(PerfEn ? 2 : 0)) begin
      miscompares++;
      $display("[TB] FAIL flush_kills_count: got %0d expected %0d", flush_kills, PerfEn ? 2 : 0);
    end
    bus.out_ready = 1'b1;
    for (int w = 0; w < 10; w++) begin
      #1;
      if (bus.out_valid) begin
        vectors++;
        if (got >= 2) begin
          miscompares++;
          $display("[TB] FAIL flush_extra_out: got id %0d expected none", bus.out_id);
        end else if (bus.out_id !== ids[got == 0 ? 0 : 2] || bus.out_address !== adr[got == 0 ? 0 : 2]) begin
          miscompares++;
          $display("[TB] FAIL flush_survivor_%0d: got %h/%0d expected %h/%0d", got, bus.out_address, bus.out_id, adr[got == 0 ? 0 : 2], ids[got == 0 ? 0 : 2]);
        end
        got++;
      end
      tick();
    end
    vectors++;
    if (got != 2) begin miscompares++; $display("[TB] FAIL flush_survivors: got %0d expected 2", got); end
  endtask

  task automatic test_flush_accept();
    do_reset();
    set_offsets(ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom));
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_address  = ADDR_W'($urandom);
    bus.in_id       = 4'd7;
    bus.in_flush    = 1'b1;
    bus.in_flush_id = 4'd7;
    tick();
    set_idle();
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (occupancy !== '0) begin miscompares++; $display("[TB] FAIL accept_kill_occupancy: got %0d expected 0", occupancy); end
    vectors++;
    if (flush_kills !== CNT_W'(PerfEn ? 1 : 0)) begin
      miscompares++;
      $display("[TB] FAIL accept_kill_count: got %0d expected %0d", flush_kills, PerfEn ? 1 : 0);
    end
    for (int w = 0; w < 6; w++) begin
      vectors++;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL accept_kill_leak_c%0d: got %0b expected 0", w, bus.out_valid); end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_offsets(8'd5, 8'd6, 8'd7, 8'd8);
    for (int k = 0; k < 3; k++) begin
      bus.in_valid   = 1'b1;
      bus.in_address = ADDR_W'($urandom);
      bus.in_id      = ID_W'(k + 1);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    vectors++;
    if (occupancy !== OCC_W'(3)) begin miscompares++; $display("[TB] FAIL midreset_prefill: got %0d expected 3", occupancy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || occupancy !== '0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: got valid %0b occ %0d ready %0b expected 0/0/1", bus.out_valid, occupancy, bus.in_ready);
    end
  endtask

  task automatic test_random();
    entry_t            q[$];
    entry_t            keep[$];
    logic [ADDR_W-1:0] o [4];
    logic [ADDR_W-1:0] sumOff;
    logic              expReady, lastFlush;
    logic [ID_W-1:0]   lastFlushId;
    int                kills;
    kills     = 0;
    lastFlush = 1'b0;
    lastFlushId = '0;
    for (int k = 0; k < 4; k++) o[k] = ADDR_W'($urandom);
    sumOff = o[0] + o[1] + o[2] + o[3];
    do_reset();
    set_offsets(o[0], o[1], o[2], o[3]);
    for (int w = 0; w < 500; w++) begin
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.in_address  = ADDR_W'($urandom);
      bus.in_id       = ID_W'($urandom_range(0, 3));
      bus.out_ready   = ($urandom_range(0, 2) != 0);
      bus.in_flush    = ($urandom_range(0, 7) == 0);
      bus.in_flush_id = ID_W'($urandom_range(0, 3));
      #1;
      expReady = (q.size() < DEPTH) || bus.out_ready;
      vectors++;
      if (bus.in_ready !== expReady) begin miscompares++; $display("[TB] FAIL rnd_in_ready_c%0d: got %0b expected %0b", w, bus.in_ready, expReady); end
      vectors++;
      if (occupancy !== OCC_W'(q.size())) begin miscompares++; $display("[TB] FAIL rnd_occupancy_c%0d: got %0d expected %0d", w, occupancy, q.size()); end
      if (bus.out_valid === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL rnd_phantom_c%0d: got out_valid 1 expected empty pipe", w);
        end else if (bus.out_address !== q[0].addr || bus.out_id !== q[0].id) begin
          miscompares++;
          $display("[TB] FAIL rnd_head_c%0d: got %h/%0d expected %h/%0d", w, bus.out_address, bus.out_id, q[0].addr, q[0].id);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready && q.size() > 0) void'(q.pop_front());
      if (bus.in_valid && expReady) q.push_back('{addr: bus.in_address + sumOff, id: bus.in_id});
      if (bus.in_flush) begin
        keep.delete();
        foreach (q[j]) begin
          if (q[j].id == bus.in_flush_id) kills++;
          else keep.push_back(q[j]);
        end
        q = keep;
      end
      lastFlush   = bus.in_flush;
      lastFlushId = bus.in_flush_id;
      tick();
      vectors++;
      if (bus.out_flush !== lastFlush || (lastFlush && bus.out_flush_id !== lastFlushId)) begin
        miscompares++;
        $display("[TB] FAIL rnd_flush_echo_c%0d: got %0b/%0d expected %0b/%0d", w, bus.out_flush, bus.out_flush_id, lastFlush, lastFlushId);
      end
    end
    #1;
    vectors++;
    if (flush_kills !== CNT_W'(PerfEn ? kills : 0)) begin
      miscompares++;
      $display("[TB] FAIL rnd_flush_kills: got %0d expected %0d", flush_kills, PerfEn ? kills : 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    bus.stage_offsets = '0;
    test_reset();
    test_latency();
    test_wrap();
    test_backpressure();
    test_flush_multi();
    test_flush_accept();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: got no completion expected finish within 1ms");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
